// File: rtl/cdc_bus_handshake_if.sv
// Signal bundle for cdc_bus_handshake: master-domain command/response side
// and slave-domain command side, each seen through its own modport.
interface cdc_bus_handshake_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned RESP_W = 8
);
  logic              m_valid_i;
  logic              m_ready_o;
  logic [DATA_W-1:0] m_data_i;
  logic              m_resp_valid_o;
  logic [RESP_W-1:0] m_resp_o;

  logic              s_valid_o;
  logic              s_ready_i;
  logic [DATA_W-1:0] s_data_o;
  logic [RESP_W-1:0] s_resp_i;

  modport master (
    input  m_valid_i,
    input  m_data_i,
    output m_ready_o,
    output m_resp_valid_o,
    output m_resp_o
  );

  modport slave (
    output s_valid_o,
    output s_data_o,
    input  s_ready_i,
    input  s_resp_i
  );
endinterface

// File: rtl/cdc_bus_handshake.sv
// Single-outstanding command/response bridge between two unrelated clocks,
// signalled with toggle flags; payloads cross via holding registers.
module cdc_bus_handshake #(
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned RESP_W         = 8,
  parameter bit          RESP_EN        = 1'b1,
  parameter int unsigned CDC_REG_AMOUNT = 2
) (
  input  logic                clk_m_i,
  input  logic                rst_m_i,
  input  logic                clk_s_i,
  input  logic                rst_s_i,
  cdc_bus_handshake_if.master m_if,
  cdc_bus_handshake_if.slave  s_if
);

  localparam int unsigned SYNC_W = CDC_REG_AMOUNT + 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } m_state_t;

  // Master domain
  m_state_t          r_m_state;
  m_state_t          w_m_state_nxt;
  logic [DATA_W-1:0] r_m_hold;
  logic [DATA_W-1:0] w_m_hold_nxt;
  logic              r_m_req;
  logic              w_m_req_nxt;
  logic [RESP_W-1:0] r_m_resp;
  logic [RESP_W-1:0] w_m_resp_nxt;
  logic              r_m_resp_valid;
  logic              w_m_resp_valid_nxt;
  logic [SYNC_W-1:0] r_m_ack_sync;
  logic              w_m_ack_evt;

  // Slave domain
  logic              r_s_valid;
  logic [DATA_W-1:0] r_s_data;
  logic [RESP_W-1:0] r_s_resp_hold;
  logic              r_s_ack;
  logic [SYNC_W-1:0] r_s_req_sync;
  logic              w_s_req_evt;
  logic              w_s_hs;

  assign w_m_ack_evt = r_m_ack_sync[CDC_REG_AMOUNT] ^ r_m_ack_sync[CDC_REG_AMOUNT-1];
  assign w_s_req_evt = r_s_req_sync[CDC_REG_AMOUNT] ^ r_s_req_sync[CDC_REG_AMOUNT-1];
  assign w_s_hs      = r_s_valid & s_if.s_ready_i;

  always_ff @(posedge clk_m_i or posedge rst_m_i) begin
    if (rst_m_i) begin
      r_m_state <= ST_IDLE;
    end else begin
      r_m_state <= w_m_state_nxt;
    end
  end

  // Accept in IDLE, complete on the synchronised ack edge in BUSY.
  always_comb begin
    w_m_state_nxt      = r_m_state;
    w_m_hold_nxt       = r_m_hold;
    w_m_req_nxt        = r_m_req;
    w_m_resp_nxt       = r_m_resp;
    w_m_resp_valid_nxt = 1'b0;
    case (r_m_state)
      ST_IDLE: begin
        if (m_if.m_valid_i) begin
          w_m_state_nxt = ST_BUSY;
          w_m_hold_nxt  = m_if.m_data_i;
          w_m_req_nxt   = ~r_m_req;
        end
      end
      ST_BUSY: begin
        if (w_m_ack_evt) begin
          w_m_state_nxt      = ST_IDLE;
          w_m_resp_valid_nxt = 1'b1;
          w_m_resp_nxt       = RESP_EN ? r_s_resp_hold : '0;
        end
      end
      default: w_m_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_m_i or posedge rst_m_i) begin
    if (rst_m_i) begin
      r_m_hold       <= '0;
      r_m_req        <= 1'b0;
      r_m_resp       <= '0;
      r_m_resp_valid <= 1'b0;
      r_m_ack_sync   <= '0;
    end else begin
      r_m_hold       <= w_m_hold_nxt;
      r_m_req        <= w_m_req_nxt;
      r_m_resp       <= w_m_resp_nxt;
      r_m_resp_valid <= w_m_resp_valid_nxt;
      r_m_ack_sync   <= {r_m_ack_sync[SYNC_W-2:0], r_s_ack};
    end
  end

  // r_m_hold is frozen while the request toggle is in flight, so a plain
  // multi-bit capture on the synchronised request edge is safe.
  always_ff @(posedge clk_s_i or posedge rst_s_i) begin
    if (rst_s_i) begin
      r_s_valid     <= 1'b0;
      r_s_data      <= '0;
      r_s_resp_hold <= '0;
      r_s_ack       <= 1'b0;
      r_s_req_sync  <= '0;
    end else begin
      r_s_req_sync <= {r_s_req_sync[SYNC_W-2:0], r_m_req};
      if (w_s_hs) begin
        r_s_valid <= 1'b0;
        r_s_ack   <= ~r_s_ack;
        if (RESP_EN) begin
          r_s_resp_hold <= s_if.s_resp_i;
        end
      end else if (w_s_req_evt) begin
        r_s_valid <= 1'b1;
        r_s_data  <= r_m_hold;
      end
    end
  end

  assign m_if.m_ready_o      = (r_m_state == ST_IDLE);
  assign m_if.m_resp_valid_o = r_m_resp_valid;
  assign m_if.m_resp_o       = r_m_resp;
  assign s_if.s_valid_o      = r_s_valid;
  assign s_if.s_data_o       = r_s_data;

endmodule

// File: tb/tb_cdc_bus_handshake.sv
// Bench for cdc_bus_handshake: directed vectors, reset and hold sequences,
// then random traffic at two clock ratios against a queue-based model.
module tb_cdc_bus_handshake;

  localparam int unsigned DW   = 32;
  localparam int unsigned RW   = 8;
  localparam int unsigned CDC0 = 2;
  localparam int unsigned CDC1 = 3;
  localparam int          NV   = 5;

  logic clk_m = 1'b0;
  logic clk_s = 1'b0;
  logic rst_m = 1'b1;
  logic rst_s = 1'b1;
  int   hp_m  = 5;
  int   hp_s  = 5;

  initial forever #hp_m clk_m = ~clk_m;
  initial begin
    #2;
    forever #hp_s clk_s = ~clk_s;
  end

  cdc_bus_handshake_if #(.DATA_W(DW), .RESP_W(RW)) bif0 ();
  cdc_bus_handshake_if #(.DATA_W(DW), .RESP_W(RW)) bif1 ();

  cdc_bus_handshake #(.DATA_W(DW), .RESP_W(RW), .RESP_EN(1'b1), .CDC_REG_AMOUNT(CDC0)) dut0 (
    .clk_m_i(clk_m), .rst_m_i(rst_m), .clk_s_i(clk_s), .rst_s_i(rst_s),
    .m_if(bif0.master), .s_if(bif0.slave)
  );

  cdc_bus_handshake #(.DATA_W(DW), .RESP_W(RW), .RESP_EN(1'b0), .CDC_REG_AMOUNT(CDC1)) dut1 (
    .clk_m_i(clk_m), .rst_m_i(rst_m), .clk_s_i(clk_s), .rst_s_i(rst_s),
    .m_if(bif1.master), .s_if(bif1.slave)
  );

  typedef struct {
    logic [31:0] data;
    logic [7:0]  resp;
    logic [31:0] exp_data;
    logic [7:0]  exp_resp;
  } vec_t;
  vec_t vecs [NV];

  // Reference model: words accepted by the master, responses taken by the slave.
  logic [31:0] word_q[$];
  logic [7:0]  resp_q[$];

  int n_chk = 0;
  int n_err = 0;

  int          m_left      = 0;
  int          m_valid_pct = 100;
  bit          m_rand_data = 1'b0;
  logic [31:0] m_data_fix  = '0;
  int          s_ready_pct = 100;
  bit          s_rand_resp = 1'b0;
  logic [7:0]  s_resp_fix  = '0;

  int          n_done  = 0;
  int          n_acc   = 0;
  int          n_rx    = 0;
  int          n_b2b   = 0;
  int          last_rt = 0;
  longint      t_acc   = 0;
  longint      t_hs    = 0;
  logic [31:0] last_rx = '0;

  bit          s_pv  = 1'b0;
  bit          s_phs = 1'b0;
  logic [31:0] s_pd  = '0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic chk_rng(input string name, input longint got, input longint lo, input longint hi);
    n_chk++;
    if (got < lo || got > hi) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, got, lo, hi);
    end
  endtask

  task automatic fail(input string name);
    n_chk++;
    n_err++;
    $display("FAIL %s: expected event missing or unexpected event seen", name);
  endtask

  function automatic longint ceil_div(input longint a, input longint b);
    return (a + b - 1) / b;
  endfunction

  // Master side: completion checks, ready model, command driver, accept log.
  always @(negedge clk_m) begin
    if (rst_m) begin
      bif0.m_valid_i = 1'b0;
      bif0.m_data_i  = '0;
    end else begin
      if (bif0.m_resp_valid_o) begin
        n_done++;
        if (resp_q.size() == 0) fail("spurious m_resp_valid_o");
        else chk("m_resp_o", bif0.m_resp_o, resp_q.pop_front());
        chk_rng("ack latency", ceil_div(longint'($time) - hp_m - t_hs, 2 * hp_m), CDC0, CDC0 + 2);
        last_rt = int'(ceil_div(longint'($time) - hp_m - t_acc, 2 * hp_m));
      end
      chk("m_ready_o", bif0.m_ready_o, (n_acc == n_done) ? 1 : 0);
      if (m_left > 0 && $urandom_range(99) < m_valid_pct) begin
        bif0.m_valid_i = 1'b1;
        bif0.m_data_i  = m_rand_data ? $urandom : m_data_fix;
      end else begin
        bif0.m_valid_i = 1'b0;
      end
      if (bif0.m_valid_i && bif0.m_ready_o) begin
        word_q.push_back(bif0.m_data_i);
        m_left--;
        n_acc++;
        t_acc = longint'($time) + hp_m;
        if (bif0.m_resp_valid_o) n_b2b++;
      end
    end
  end

  // Slave side: stability and latency checks, random stalls, delivery order.
  always @(negedge clk_s) begin
    if (rst_s) begin
      bif0.s_ready_i = 1'b0;
      bif0.s_resp_i  = '0;
      s_pv  = 1'b0;
      s_phs = 1'b0;
    end else begin
      if (s_pv && !s_phs)
        chk("s_valid/s_data hold", {bif0.s_valid_o, bif0.s_data_o}, {1'b1, s_pd});
      if (bif0.s_valid_o && !s_pv)
        chk_rng("req latency", ceil_div(longint'($time) - hp_s - t_acc, 2 * hp_s), CDC0, CDC0 + 2);
      bif0.s_ready_i = ($urandom_range(99) < s_ready_pct);
      bif0.s_resp_i  = s_rand_resp ? 8'($urandom) : s_resp_fix;
      s_phs = bif0.s_valid_o && bif0.s_ready_i;
      if (s_phs) begin
        if (word_q.size() == 0) fail("spurious s_valid_o");
        else chk("s_data_o order", bif0.s_data_o, word_q.pop_front());
        resp_q.push_back(bif0.s_resp_i);
        t_hs    = longint'($time) + hp_s;
        last_rx = bif0.s_data_o;
        n_rx++;
      end
      s_pv = bif0.s_valid_o;
      s_pd = bif0.s_data_o;
    end
  end

  task automatic wait_done(input int target, input int budget, input string name);
    int k = 0;
    while (n_done < target && k < budget) begin
      @(negedge clk_m);
      k++;
    end
    if (n_done < target) fail(name);
  endtask

  task automatic run_dut1(input logic [31:0] data, input int rt0);
    int     k = 0;
    longint t0;
    @(negedge clk_m);
    chk("dut1 idle m_ready_o", bif1.m_ready_o, 1);
    bif1.m_valid_i = 1'b1;
    bif1.m_data_i  = data;
    t0 = longint'($time) + hp_m;
    @(negedge clk_m);
    bif1.m_valid_i = 1'b0;
    chk("dut1 busy m_ready_o", bif1.m_ready_o, 0);
    while (!bif1.m_resp_valid_o && k < 200) begin
      @(negedge clk_m);
      k++;
    end
    if (!bif1.m_resp_valid_o) begin
      fail("dut1 completion");
    end else begin
      chk("dut1 round trip", ceil_div(longint'($time) - hp_m - t0, 2 * hp_m), rt0 + 2);
      chk("dut1 m_resp_o", bif1.m_resp_o, 0);
      chk("dut1 m_ready_o at pulse", bif1.m_ready_o, 1);
      chk("dut1 s_data_o", bif1.s_data_o, data);
      chk("dut1 s_valid_o", bif1.s_valid_o, 0);
      @(negedge clk_m);
      chk("dut1 pulse width", bif1.m_resp_valid_o, 0);
    end
  endtask

  task automatic run_random(input int n, input string name);
    int base = n_done;
    int rx0  = n_rx;
    m_rand_data = 1'b1;
    s_rand_resp = 1'b1;
    m_valid_pct = 40;
    s_ready_pct = 50;
    m_left      = n;
    wait_done(base + n, n * 60, name);
    repeat (20) @(negedge clk_m);
    chk({name, " completions"}, n_done - base, n);
    chk({name, " slave deliveries"}, n_rx - rx0, n);
    chk({name, " words left"}, word_q.size(), 0);
    chk({name, " responses left"}, resp_q.size(), 0);
    m_left = 0;
  endtask

  initial begin
    int base;
    int rt0;
    int k;
    vecs[0] = '{32'hDEADBEEF, 8'h5A, 32'hDEADBEEF, 8'h5A};
    vecs[1] = '{32'h00000000, 8'h00, 32'h00000000, 8'h00};
    vecs[2] = '{32'hFFFFFFFF, 8'hFF, 32'hFFFFFFFF, 8'hFF};
    vecs[3] = '{32'h80000001, 8'h81, 32'h80000001, 8'h81};
    vecs[4] = '{32'hA5A5A5A5, 8'h96, 32'hA5A5A5A5, 8'h96};

    bif1.m_valid_i = 1'b0;
    bif1.m_data_i  = '0;
    bif1.s_ready_i = 1'b1;
    bif1.s_resp_i  = 8'hC3;

    repeat (10) @(negedge clk_m);
    chk("rst m_ready_o", bif0.m_ready_o, 1);
    chk("rst m_resp_valid_o", bif0.m_resp_valid_o, 0);
    chk("rst m_resp_o", bif0.m_resp_o, 0);
    chk("rst s_valid_o", bif0.s_valid_o, 0);
    chk("rst s_data_o", bif0.s_data_o, 0);
    chk("rst dut1 m_ready_o", bif1.m_ready_o, 1);
    rst_m = 1'b0;
    rst_s = 1'b0;
    repeat (5) @(negedge clk_m);

    // Directed single transfers, equal clocks, slave always ready.
    for (int i = 0; i < NV; i++) begin
      m_rand_data = 1'b0;
      s_rand_resp = 1'b0;
      m_valid_pct = 100;
      s_ready_pct = 100;
      m_data_fix  = vecs[i].data;
      s_resp_fix  = vecs[i].resp;
      base        = n_done;
      m_left      = 1;
      wait_done(base + 1, 100, "table transfer");
      repeat (10) @(negedge clk_m);
      chk("table s_data_o", last_rx, vecs[i].exp_data);
      chk("table m_resp_o", bif0.m_resp_o, vecs[i].exp_resp);
      chk("table pulse count", n_done - base, 1);
    end
    rt0 = last_rt;
    chk_rng("round trip", rt0, 2 * (CDC0 + 1) - 1, 2 * (CDC0 + 1) + 3);

    // Deeper synchronisers, response path removed.
    run_dut1(32'h13579BDF, rt0);
    run_dut1(32'h2468ACE0, rt0);

    // Reset both domains while the slave holds a pending command.
    s_ready_pct = 0;
    m_rand_data = 1'b0;
    m_data_fix  = 32'h12345678;
    m_left      = 1;
    k = 0;
    while (!bif0.s_valid_o && k < 200) begin
      @(negedge clk_m);
      k++;
    end
    if (!bif0.s_valid_o) fail("pending s_valid_o before reset");
    @(negedge clk_m);
    rst_m = 1'b1;
    rst_s = 1'b1;
    repeat (2) @(negedge clk_m);
    chk("mid rst m_ready_o", bif0.m_ready_o, 1);
    chk("mid rst m_resp_valid_o", bif0.m_resp_valid_o, 0);
    chk("mid rst m_resp_o", bif0.m_resp_o, 0);
    chk("mid rst s_valid_o", bif0.s_valid_o, 0);
    chk("mid rst s_data_o", bif0.s_data_o, 0);
    repeat (8) @(negedge clk_m);
    word_q.delete();
    resp_q.delete();
    n_acc       = n_done;
    m_left      = 0;
    s_ready_pct = 100;
    rst_m = 1'b0;
    rst_s = 1'b0;
    base = n_done;
    repeat (20) @(negedge clk_m);
    chk("post-rst no pulse", n_done - base, 0);
    chk("post-rst s_valid_o", bif0.s_valid_o, 0);
    m_data_fix = 32'h00000001;
    s_resp_fix = 8'h3C;
    m_left     = 1;
    wait_done(base + 1, 100, "post-rst transfer");
    repeat (5) @(negedge clk_m);
    chk("post-rst s_data_o", last_rx, 32'h00000001);
    chk("post-rst m_resp_o", bif0.m_resp_o, 8'h3C);

    // Valid held high with changing data: next accept lands on each pulse.
    base        = n_done;
    k           = n_b2b;
    m_rand_data = 1'b1;
    s_rand_resp = 1'b1;
    m_valid_pct = 100;
    m_left      = 4;
    wait_done(base + 4, 200, "hold transfers");
    repeat (10) @(negedge clk_m);
    chk("hold completions", n_done - base, 4);
    chk("hold back-to-back accepts", n_b2b - k, 3);
    chk("hold words left", word_q.size(), 0);

    hp_m = 5;
    hp_s = 15;
    repeat (4) @(negedge clk_m);
    run_random(400, "slow slave");

    hp_m = 7;
    hp_s = 1;
    repeat (4) @(negedge clk_m);
    run_random(400, "fast slave");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #3000000;
    n_err++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
